// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 16-bit RISC datapath.
// Steps FETCH/DECODE/EXEC/MEM/WB and issues one-shot commit strobes, with memory timeout and step control.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic [3:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ir_load,
    output logic             jump,
    output logic             beq,
    output logic             bne,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             alu_src,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [1:0]       alu_op,
    output logic             illegal_op,
    output logic             bus_err,
    output logic             busy,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state_o
);

    // state   | meaning
    // FETCH   | idle / load IR when run or a pending step allows it
    // DECODE  | J and illegal opcodes commit here
    // EXEC    | branches commit here; others go to MEM or WB
    // MEM     | LW/SW wait on mem_ready with timeout
    // WB      | register write and commit
    // FAULT   | memory timeout; parked until reset
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic               step_pending_q, step_pending_d;
    logic [7:0]         wait_q, wait_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic is_lw, is_sw, is_r, is_beq, is_bne, is_j, is_ill;
    logic pc_en_c, ir_load_c, jump_c, beq_c, bne_c, rd_c, wr_c, rw_c, ill_c;
    logic alu_src_c, reg_dst_c, m2r_c, busy_c;
    logic [1:0] alu_op_c;

    assign is_lw  = (op_q == 4'd0);
    assign is_sw  = (op_q == 4'd1);
    assign is_r   = (op_q >= 4'd2) && (op_q <= 4'd9);
    assign is_beq = (op_q == 4'd11);
    assign is_bne = (op_q == 4'd12);
    assign is_j   = (op_q == 4'd13);
    assign is_ill = (op_q == 4'd10) || (op_q == 4'd14) || (op_q == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_FETCH;
            op_q           <= 4'd0;
            step_pending_q <= 1'b0;
            wait_q         <= 8'd0;
            bus_err_q      <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            step_pending_q <= step_pending_d;
            wait_q         <= wait_d;
            bus_err_q      <= bus_err_d;
            count_q        <= count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        step_pending_d = step_pending_q | step;
        wait_d         = 8'd0;
        bus_err_d      = bus_err_q;
        pc_en_c        = 1'b0;
        ir_load_c      = 1'b0;
        jump_c         = 1'b0;
        beq_c          = 1'b0;
        bne_c          = 1'b0;
        rd_c           = 1'b0;
        wr_c           = 1'b0;
        rw_c           = 1'b0;
        ill_c          = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run || step_pending_q) begin
                    ir_load_c      = 1'b1;
                    op_d           = opcode;
                    step_pending_d = step;
                    state_d        = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_j) begin
                    jump_c  = 1'b1;
                    pc_en_c = 1'b1;
                    state_d = S_FETCH;
                end else if (is_ill) begin
                    ill_c   = 1'b1;
                    pc_en_c = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq || is_bne) begin
                    beq_c   = is_beq;
                    bne_c   = is_bne;
                    pc_en_c = 1'b1;
                    state_d = S_FETCH;
                end else if (is_r) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                rd_c = is_lw;
                wr_c = is_sw;
                // mem_ready takes priority over a timeout landing in the same cycle
                if (mem_ready) begin
                    if (is_sw) begin
                        pc_en_c = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if ((wait_q + 8'd1) == TIMEOUT) begin
                    bus_err_d = 1'b1;
                    state_d   = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                rw_c    = 1'b1;
                pc_en_c = 1'b1;
                state_d = S_FETCH;
            end
            S_FAULT: begin
                step_pending_d = 1'b0;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alu_op_c  = 2'b00;
        alu_src_c = 1'b0;
        reg_dst_c = 1'b0;
        m2r_c     = 1'b0;
        busy_c    = (state_q != S_FETCH) && (state_q != S_FAULT);
        if (busy_c) begin
            if (is_lw) begin
                alu_op_c  = 2'b10;
                alu_src_c = 1'b1;
                m2r_c     = 1'b1;
            end else if (is_sw) begin
                alu_op_c  = 2'b10;
                alu_src_c = 1'b1;
            end else if (is_r) begin
                reg_dst_c = 1'b1;
            end else if (is_beq || is_bne) begin
                alu_op_c  = 2'b01;
            end
        end
    end

    assign count_d = pc_en_c ? count_q + CNT_W'(1) : count_q;

    // Strobes are suppressed while rst is high so nothing commits in the reset cycle.
    assign pc_en       = pc_en_c & ~rst;
    assign ir_load     = ir_load_c & ~rst;
    assign jump        = jump_c & ~rst;
    assign beq         = beq_c & ~rst;
    assign bne         = bne_c & ~rst;
    assign mem_read    = rd_c & ~rst;
    assign mem_write   = wr_c & ~rst;
    assign reg_write   = rw_c & ~rst;
    assign illegal_op  = ill_c & ~rst;
    assign alu_src     = alu_src_c & ~rst;
    assign reg_dst     = reg_dst_c & ~rst;
    assign mem_to_reg  = m2r_c & ~rst;
    assign alu_op      = alu_op_c & {2{~rst}};
    assign busy        = busy_c & ~rst;
    assign bus_err     = bus_err_q;
    assign instr_count = count_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: table of instructions with a commit scoreboard,
// plus hand sequences for free-run, single-step, counter wrap, reset in MEM and timeout.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst, run, step, mem_ready;
    logic [3:0] opcode;
    logic       pc_en, ir_load, jump, beq, bne, mem_read, mem_write, reg_write;
    logic       alu_src, reg_dst, mem_to_reg, illegal_op, bus_err, busy;
    logic [1:0] alu_op;
    logic [3:0] instr_count;
    logic [2:0] state_o;

    multicycle_sequencer #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode),
        .mem_ready(mem_ready), .pc_en(pc_en), .ir_load(ir_load), .jump(jump),
        .beq(beq), .bne(bne), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .alu_src(alu_src), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_op(alu_op), .illegal_op(illegal_op),
        .bus_err(bus_err), .busy(busy), .instr_count(instr_count), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // flags = {jump,beq,bne,illegal_op,reg_write}; dec = {alu_op,alu_src,reg_dst,mem_to_reg}
    typedef struct {
        logic [3:0] op;
        int waits;
        int cyc;
        int st;
        int flags;
        int dec;
        int rd;
        int wr;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[12];
    vec_t e;
    int total = 0;
    int bad = 0;
    int pc_seen = 0;
    logic [3:0] model_cnt = 4'd0;

    int  mon_cyc = 0, mon_rd = 0, mon_wr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({pc_en, ir_load, jump, beq, bne, mem_read, mem_write, reg_write,
                     alu_src, reg_dst, mem_to_reg, alu_op, illegal_op, bus_err, busy});
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            mon_cyc = 0; mon_rd = 0; mon_wr = 0;
        end else begin
            if (ir_load) begin
                mon_cyc = 1; mon_rd = 0; mon_wr = 0;
            end else begin
                mon_cyc++;
            end
            if (mem_read)  mon_rd++;
            if (mem_write) mon_wr++;
            if (pc_en) begin
                pc_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pc_en", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("op%0d_cycles", e.op), mon_cyc, e.cyc);
                    chk($sformatf("op%0d_commit_state", e.op), int'(state_o), e.st);
                    chk($sformatf("op%0d_flags", e.op),
                        int'({jump, beq, bne, illegal_op, reg_write}), e.flags);
                    chk($sformatf("op%0d_decode", e.op),
                        int'({alu_op, alu_src, reg_dst, mem_to_reg}), e.dec);
                    chk($sformatf("op%0d_mem_read_cycles", e.op), mon_rd, e.rd);
                    chk($sformatf("op%0d_mem_write_cycles", e.op), mon_wr, e.wr);
                end
            end else begin
                chk("strobe_without_pc_en", int'({jump, beq, bne, illegal_op, reg_write}), 0);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        model_cnt = 4'd0;
    endtask

    task automatic pulse_step();
        @(posedge clk);
        #1 step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
    endtask

    // Runs until the DUT returns to FETCH, answering MEM after `waits` stalls.
    task automatic wait_done(input int waits);
        bit left = 0;
        bit done = 0;
        int mcyc = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk);
            #1;
            if (state_o == 3'd3) begin
                mem_ready = (mcyc >= waits);
                mcyc++;
            end else begin
                mem_ready = 1'b0;
            end
            if (state_o != 3'd0) left = 1;
            else if (left) done = 1;
        end
        mem_ready = 1'b0;
        if (!done) chk("instr_timeout", 0, 1);
    endtask

    task automatic exec_one(input vec_t v);
        opcode = v.op;
        exp_q.push_back(v);
        model_cnt = model_cnt + 4'd1;
        pulse_step();
        wait_done(v.waits);
        chk($sformatf("op%0d_committed", v.op), exp_q.size(), 0);
    endtask

    initial begin
        int st[5];
        int base;
        int mcyc;
        bit hit;
        vec_t v;
        tbl[0]  = '{4'd0,  0, 5, 4, 1,  21, 1, 0};
        tbl[1]  = '{4'd0,  3, 8, 4, 1,  21, 4, 0};
        tbl[2]  = '{4'd1,  0, 4, 3, 0,  20, 0, 1};
        tbl[3]  = '{4'd1,  2, 6, 3, 0,  20, 0, 3};
        tbl[4]  = '{4'd2,  0, 4, 4, 1,  2,  0, 0};
        tbl[5]  = '{4'd9,  0, 4, 4, 1,  2,  0, 0};
        tbl[6]  = '{4'd11, 0, 3, 2, 8,  8,  0, 0};
        tbl[7]  = '{4'd12, 0, 3, 2, 4,  8,  0, 0};
        tbl[8]  = '{4'd13, 0, 2, 1, 16, 0,  0, 0};
        tbl[9]  = '{4'd10, 0, 2, 1, 2,  0,  0, 0};
        tbl[10] = '{4'd14, 0, 2, 1, 2,  0,  0, 0};
        tbl[11] = '{4'd15, 0, 2, 1, 2,  0,  0, 0};

        rst = 1'b1; run = 1'b0; step = 1'b0; opcode = 4'd0; mem_ready = 1'b0;
        do_reset();
        @(negedge clk);
        chk("reset_state", int'(state_o), 0);
        chk("reset_count", int'(instr_count), 0);
        chk("reset_outputs", all_outs(), 0);

        // Free-running ADD, dropping run once it has been fetched.
        opcode = 4'd2;
        exp_q.push_back(tbl[4]);
        model_cnt = model_cnt + 4'd1;
        @(posedge clk);
        #1 run = 1'b1;
        @(negedge clk);
        st[0] = int'(state_o);
        @(posedge clk);
        #1 run = 1'b0;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            st[i] = int'(state_o);
        end
        chk("add_state0", st[0], 0);
        chk("add_state1", st[1], 1);
        chk("add_state2", st[2], 2);
        chk("add_state3", st[3], 4);
        chk("add_state4", st[4], 0);
        chk("add_count", int'(instr_count), 1);

        foreach (tbl[i]) exec_one(tbl[i]);
        @(negedge clk);
        chk("table_count", int'(instr_count), int'(model_cnt));

        // Two single steps ten cycles apart: BEQ then J.
        base = pc_seen;
        opcode = 4'd11;
        exp_q.push_back(tbl[6]);
        exp_q.push_back(tbl[8]);
        model_cnt = model_cnt + 4'd2;
        pulse_step();
        repeat (5) @(posedge clk);
        #1 opcode = 4'd13;
        repeat (4) @(posedge clk);
        pulse_step();
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("step_pc_en_count", pc_seen - base, 2);
        chk("step_state_idle", int'(state_o), 0);
        chk("count_before_wrap", int'(instr_count), 15);

        v = tbl[8];
        exec_one(v);
        @(negedge clk);
        chk("count_wrap", int'(instr_count), 0);

        // Reset landing while an LW waits in MEM.
        exec_one(v);
        opcode = 4'd0;
        pulse_step();
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (state_o == 3'd3) hit = 1;
        end
        chk("lw_reached_mem", int'(hit), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_outputs", all_outs(), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        model_cnt = 4'd0;
        @(negedge clk);
        chk("post_rst_state", int'(state_o), 0);
        chk("post_rst_count", int'(instr_count), 0);
        chk("post_rst_outputs", all_outs(), 0);

        // SW with mem_ready never asserted must fault after 15 stalled cycles.
        opcode = 4'd1;
        pulse_step();
        mcyc = 0;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (state_o == 3'd3) mcyc++;
            if (state_o == 3'd7) hit = 1;
        end
        chk("fault_reached", int'(hit), 1);
        chk("fault_mem_cycles", mcyc, 15);
        run = 1'b1;
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("fault_state_hold", int'(state_o), 7);
            chk("fault_outputs", all_outs(), 2);
        end
        chk("fault_count", int'(instr_count), 0);
        run = 1'b0;
        do_reset();
        @(negedge clk);
        chk("bus_err_cleared", int'(bus_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog actual=running expected=finished");
        $fatal(1);
    end

endmodule
